ascon_fsm: RTL
==============

Name: ascon_fsm

Overview:
- Control FSM that sequences the ASCON-128 datapath through initialisation, associated data, plaintext and finalisation.
- The datapath it drives is the state register, the begin/end XOR stages and the round-parameterised permutation.
- Each permutation round takes one clock cycle.
- Drives the enables of the XOR stages, the state-register load/update, the round index, ciphertext/tag capture and the upstream data handshake.

Parameters:
- NB_BLOCKS, 4, number of 64-bit plaintext blocks per message (>=1, padding pre-applied upstream); associated data is exactly one 64-bit block.
- CNT_W, 4, width of the round index.

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle pulse; starts a new encryption (key/nonce stable on datapath).
- data_valid_i  in  1  current AD/plaintext block present on datapath input.
- data_ready_o  out  1  block consumed this cycle (data_valid_i & wait state).
- round_o  out  CNT_W  permutation round index (constant-addition select).
- init_state_o  out  1  state register loads IV||K||N instead of permutation output.
- en_reg_state_o  out  1  state register update enable.
- en_xor_data_begin_o  out  1  XOR input block into rate (state[0]).
- en_xor_key_begin_o  out  1  XOR key into state[1],state[2].
- en_xor_key_end_o  out  1  XOR key into state[3],state[4] after round.
- en_xor_lsb_o  out  1  XOR domain-separation bit into state[4] LSB.
- en_cipher_o  out  1  capture ciphertext register.
- en_tag_o  out  1  capture tag register.
- cipher_valid_o  out  1  registered; ciphertext register valid (1 cycle after en_cipher_o).
- block_cnt_o  out  $clog2(NB_BLOCKS+1)  plaintext blocks consumed.
- end_o  out  1  tag valid; held until next start_i.

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE; round counter = 0; block_cnt_o = 0.
  - All outputs = 0. Reset mid-message aborts with no further enables.
- States:
  - IDLE, INIT, AD_WAIT, AD_PERM, PT_WAIT, PT_PERM, FIN, DONE.
- IDLE/DONE:
  - start_i -> INIT; round loads 0; end_o cleared on the same edge.
  - start_i is ignored in every other state.
- INIT (rounds 0..11, 12 cycles):
  - en_reg_state_o = 1.
  - Round 0: init_state_o = 1.
  - Round 11: en_xor_key_end_o = 1, then -> AD_WAIT.
- AD_WAIT:
  - Outputs idle. On data_valid_i: data_ready_o = 1, en_xor_data_begin_o = 1, en_reg_state_o = 1.
  - This cycle is round 6; -> AD_PERM with round 7.
- AD_PERM (rounds 7..11):
  - Round 11: en_xor_lsb_o = 1, then -> PT_WAIT.
- PT_WAIT, on data_valid_i:
  - data_ready_o = 1, en_xor_data_begin_o = 1, en_cipher_o = 1, en_reg_state_o = 1; block_cnt_o increments.
  - If block_cnt_o < NB_BLOCKS-1: this cycle is round 6 -> PT_PERM with round 7.
  - Else (last block): en_xor_key_begin_o = 1 also; this cycle is round 0 -> FIN with round 1.
- PT_PERM (rounds 7..11):
  - Round 11 -> PT_WAIT.
- FIN (rounds 1..11):
  - Round 11: en_xor_key_end_o = 1, en_tag_o = 1, then -> DONE.
  - end_o = 1 from the next cycle.
- Outputs and counter:
  - Outputs are a combinational decode of state + round + data_valid_i.
  - cipher_valid_o, end_o and block_cnt_o are registered.
  - Round counter saturates at 11 only in DONE/IDLE; it never wraps inside a phase.
- data_valid_i:
  - Ignored outside AD_WAIT/PT_WAIT.
  - If held high across permutation phases, exactly one block is consumed per wait state.
- Latency from start_i to end_o, with data_valid_i always high:
  - 12 + 6 + 6*(NB_BLOCKS-1) + 12 cycles, +1 for end_o registration.
  - NB_BLOCKS=4: 48 + 1 = 49 cycles.

Decomposition:
- ascon_pack holds:
  - fsm_state_t enum.
  - Constants ROUND_PA_START=0, ROUND_PB_START=6, ROUND_LAST=11.
  - The existing type_state.
- Sub-module round_counter:
  - Inputs: clock_i, reset_i, load_i, load_val_i (0/6), en_i.
  - Output: round_o.
- The FSM instantiates round_counter; the block counter is kept inline.

Test Plan:
- Reset asserted mid-INIT at round 5 -> all outputs 0 immediately (async); round_o=0; after release, no enables until start_i.
- start_i with data_valid_i tied high, NB_BLOCKS=4 -> init_state_o at cycle 1; en_xor_key_end_o at cycles 12 and 48; en_xor_lsb_o at cycle 18; en_tag_o at cycle 48; end_o=1 at cycle 49.
- data_valid_i low for 10 cycles in AD_WAIT -> FSM holds; en_reg_state_o=0, round_o=6 held; on rise, data_ready_o=1 for exactly one cycle.
- Plaintext blocks -> en_cipher_o pulses 4 times; cipher_valid_o one cycle after each; block_cnt_o ends at 4; last pulse coincides with en_xor_key_begin_o and round_o=0.
- start_i pulsed during PT_PERM -> ignored; sequence completes unchanged. start_i in DONE -> end_o clears and INIT restarts.
- NB_BLOCKS=1 -> single plaintext cycle goes directly to FIN; end_o after 12+6+12+1 = 31 cycles.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared types and round constants for the ASCON-128 control path.
package ascon_pack;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        AD_WAIT,
        AD_PERM,
        PT_WAIT,
        PT_PERM,
        FIN,
        DONE
    } fsm_state_t;

    // p^a runs rounds 0..11, p^b runs rounds 6..11 (the wait cycle is round 6)
    localparam int ROUND_PA_START = 0;
    localparam int ROUND_PB_START = 6;
    localparam int ROUND_LAST     = 11;

    typedef logic [63:0] type_state [0:4];

endpackage

// File: rtl/round_counter.sv
// Permutation round index: loadable start value, increments once per round, holds at the last round.
module round_counter
    import ascon_pack::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] round_o
);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            round_o <= '0;
        end else if (load_i) begin
            round_o <= load_val_i;
        end else if (en_i && (round_o != CNT_W'(ROUND_LAST))) begin
            round_o <= round_o + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ascon_fsm.sv
// ASCON-128 encryption sequencer: init, one AD block, NB_BLOCKS plaintext blocks, finalisation.
module ascon_fsm
    import ascon_pack::*;
#(
    parameter int NB_BLOCKS = 4,
    parameter int CNT_W     = 4
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic                           start_i,
    input  logic                           data_valid_i,
    output logic                           data_ready_o,
    output logic [CNT_W-1:0]               round_o,
    output logic                           init_state_o,
    output logic                           en_reg_state_o,
    output logic                           en_xor_data_begin_o,
    output logic                           en_xor_key_begin_o,
    output logic                           en_xor_key_end_o,
    output logic                           en_xor_lsb_o,
    output logic                           en_cipher_o,
    output logic                           en_tag_o,
    output logic                           cipher_valid_o,
    output logic [$clog2(NB_BLOCKS+1)-1:0] block_cnt_o,
    output logic                           end_o
);

    localparam int BW = $clog2(NB_BLOCKS + 1);

    fsm_state_t       state;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_en;
    logic             round_last;
    logic             last_blk;
    logic [CNT_W-1:0] pt_round_start;

    round_counter #(
        .CNT_W(CNT_W)
    ) u_round_counter (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .load_i    (cnt_load),
        .load_val_i(cnt_load_val),
        .en_i      (cnt_en),
        .round_o   (round_o)
    );

    assign round_last = (round_o == CNT_W'(ROUND_LAST));
    assign last_blk   = (block_cnt_o == BW'(NB_BLOCKS - 1));
    // The last plaintext block shares its cycle with round 0 of the final p^a
    assign pt_round_start = last_blk ? CNT_W'(ROUND_PA_START) : CNT_W'(ROUND_PB_START);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state          <= IDLE;
            block_cnt_o    <= '0;
            cipher_valid_o <= 1'b0;
            end_o          <= 1'b0;
        end else begin
            cipher_valid_o <= en_cipher_o;
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state       <= INIT;
                        block_cnt_o <= '0;
                        end_o       <= 1'b0;
                    end
                end
                INIT:    if (round_last) state <= AD_WAIT;
                AD_WAIT: if (data_valid_i) state <= AD_PERM;
                AD_PERM: if (round_last) state <= PT_WAIT;
                PT_WAIT: begin
                    if (data_valid_i) begin
                        block_cnt_o <= block_cnt_o + BW'(1);
                        state       <= last_blk ? FIN : PT_PERM;
                    end
                end
                PT_PERM: if (round_last) state <= PT_WAIT;
                FIN: begin
                    if (round_last) begin
                        state <= DONE;
                        end_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        data_ready_o        = 1'b0;
        init_state_o        = 1'b0;
        en_reg_state_o      = 1'b0;
        en_xor_data_begin_o = 1'b0;
        en_xor_key_begin_o  = 1'b0;
        en_xor_key_end_o    = 1'b0;
        en_xor_lsb_o        = 1'b0;
        en_cipher_o         = 1'b0;
        en_tag_o            = 1'b0;
        cnt_load            = 1'b0;
        cnt_load_val        = CNT_W'(ROUND_PA_START);
        cnt_en              = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_i) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(ROUND_PA_START);
                end
            end
            INIT: begin
                en_reg_state_o = 1'b1;
                init_state_o   = (round_o == CNT_W'(ROUND_PA_START));
                if (round_last) begin
                    en_xor_key_end_o = 1'b1;
                    cnt_load         = 1'b1;
                    cnt_load_val     = CNT_W'(ROUND_PB_START);
                end else begin
                    cnt_en = 1'b1;
                end
            end
            AD_WAIT: begin
                if (data_valid_i) begin
                    data_ready_o        = 1'b1;
                    en_xor_data_begin_o = 1'b1;
                    en_reg_state_o      = 1'b1;
                    cnt_en              = 1'b1;
                end
            end
            AD_PERM, PT_PERM: begin
                en_reg_state_o = 1'b1;
                if (round_last) begin
                    en_xor_lsb_o = (state == AD_PERM);
                    cnt_load     = 1'b1;
                    cnt_load_val = pt_round_start;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            PT_WAIT: begin
                if (data_valid_i) begin
                    data_ready_o        = 1'b1;
                    en_xor_data_begin_o = 1'b1;
                    en_cipher_o         = 1'b1;
                    en_reg_state_o      = 1'b1;
                    en_xor_key_begin_o  = last_blk;
                    cnt_en              = 1'b1;
                end
            end
            FIN: begin
                en_reg_state_o = 1'b1;
                if (round_last) begin
                    en_xor_key_end_o = 1'b1;
                    en_tag_o         = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
